// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: definitions shared by the memory-mapped UART transmitter.
//   - register word offsets (mem_addr[3:2]) inside the 16-byte window
//   - STATUS register bit positions
//   - transmit FSM state encoding
package mmio_uart_tx_pkg;

  // Word offsets inside the register window
  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;

  // STATUS register bit positions
  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_EMPTY   = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_MSB = 8;

  // Transmit FSM state encoding
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_START = 2'd1;
  localparam logic [1:0] STATE_DATA  = 2'd2;
  localparam logic [1:0] STATE_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = STATE_IDLE,
    S_START = STATE_START,
    S_DATA  = STATE_DATA,
    S_STOP  = STATE_STOP
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: data-memory bus between the MEM stage (master) and a
// memory-mapped responder (slave).
//   mem_addr  : byte address            (master -> slave)
//   mem_wdata : store data              (master -> slave)
//   mem_we    : one-cycle store strobe  (master -> slave)
//   mem_rdata : load data, same cycle   (slave -> master)
//   hit       : address is in window    (slave -> master)
interface mmio_uart_tx_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        hit;

  modport master (output mem_addr, output mem_wdata, output mem_we,
                  input  mem_rdata, input  hit);
  modport slave  (input  mem_addr, input  mem_wdata, input  mem_we,
                  output mem_rdata, output hit);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo_w8: byte-wide synchronous FIFO with show-ahead output.
//   clock, reset : clock and synchronous active-high reset (flushes pointers)
//   push, din    : write request and data; accepted when not full, or when
//                  full but popping in the same cycle
//   pop          : read request; ignored when empty
//   dout         : current head entry (valid when not empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module sync_fifo_w8 #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push_s;
  logic        do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign count     = wr_ptr_q - rd_ptr_q;
  assign full      = (count == CNT_DEPTH);
  assign empty     = (count == '0);
  assign do_pop_s  = pop && !empty;
  // A full FIFO can still take a byte when the head leaves in the same cycle
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array; contents need no reset because the pointers qualify them
  always_ff @(posedge clock) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  // Read/write pointer update with synchronous flush
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter on the data-memory bus.
//   clock, reset : clock and synchronous active-high reset
//   bus          : slave side of the MEM-stage bus (addr/wdata/we in,
//                  combinational rdata/hit out)
//   txd          : registered serial line, idle high
//   tx_busy      : FSM active or bytes still queued
// Register window (word offset mem_addr[3:2]):
//   0 TXDATA (write pushes byte), 1 STATUS, 2 DIV, 3 reserved.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_00C0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic             clock,
  input  logic             reset,
  mmio_uart_tx_if.slave    bus,
  output logic             txd,
  output logic             tx_busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_cur_q, div_cur_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic        txd_q, txd_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;

  logic [1:0]    ofs_s;
  logic          wr_s;
  logic          push_s;
  logic          pop_s;
  logic          bit_end_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [31:0]   status_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign bus.hit   = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign ofs_s     = bus.mem_addr[3:2];
  assign wr_s      = bus.mem_we && bus.hit;
  assign push_s    = wr_s && (ofs_s == OFS_TXDATA);
  assign bit_end_s = (baud_q == div_cur_q);
  assign tx_busy   = (state_q != S_IDLE) || !fifo_empty_s;
  assign txd       = txd_q;
  assign unused_s  = ^{bus.mem_addr[1:0], bus.mem_wdata[31:16]};

  sync_fifo_w8 #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.mem_wdata[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // STATUS word assembly and combinational load-data mux
  always_comb begin
    status_s                        = 32'd0;
    status_s[ST_BUSY]               = tx_busy;
    status_s[ST_FULL]               = fifo_full_s;
    status_s[ST_EMPTY]              = fifo_empty_s;
    status_s[ST_OVF]                = ovf_q;
    status_s[ST_CNT_MSB:ST_CNT_LSB] = 5'(fifo_count_s);
    rdata_s                         = 32'd0;
    if (bus.hit) begin
      case (ofs_s)
        OFS_STATUS: rdata_s = status_s;
        OFS_DIV:    rdata_s = {16'd0, div_q};
        default:    rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end
  assign bus.mem_rdata = rdata_s;

  // Divisor and sticky overflow next-state
  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (wr_s && (ofs_s == OFS_DIV)) begin
      div_d = bus.mem_wdata[15:0];
    end else begin
      div_d = div_q;
    end
    // Dropped byte: full FIFO and the FSM is not popping this cycle
    if (push_s && fifo_full_s && !pop_s) begin
      ovf_d = 1'b1;
    end else if (wr_s && (ofs_s == OFS_STATUS) && bus.mem_wdata[ST_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmit FSM next-state, frame datapath and registered txd value
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_cur_d = div_cur_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    pop_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_d   = fifo_dout_s;
          div_cur_d = div_q;
          bit_cnt_d = 3'd0;
          baud_d    = 16'd0;
          state_d   = S_START;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          baud_d  = 16'd0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          baud_d    = 16'd0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          baud_d    = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          baud_d = 16'd0;
          // Chain straight into the next frame when more bytes are queued
          if (!fifo_empty_s) begin
            pop_s     = 1'b1;
            shift_d   = fifo_dout_s;
            div_cur_d = div_q;
            bit_cnt_d = 3'd0;
            state_d   = S_START;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // txd follows the state being entered so the line changes on the same edge
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      div_cur_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      baud_q    <= 16'd0;
      txd_q     <= 1'b1;
      div_q     <= DIV_RESET;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_cur_q <= div_cur_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      txd_q     <= txd_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx (DIV_RESET = 3, depth 4).
// Stored bytes are pushed to a scoreboard with their expected bit length;
// a line monitor decodes each frame on txd and compares it against the head.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_00C0;

  typedef struct {
    logic [7:0] data;
    int         bl;
  } sb_t;

  logic clock = 1'b0;
  logic reset;
  logic txd;
  logic tx_busy;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  sb_t  sb_q[$];

  mmio_uart_tx_if bus_if();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4),
    .DIV_RESET  (16'd3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus_if.slave),
    .txd     (txd),
    .tx_busy (tx_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_sb(input logic [7:0] d, input int bl);
    sb_t e;
    e.data = d;
    e.bl   = bl;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    bus_if.mem_addr  = a;
    bus_if.mem_wdata = d;
    bus_if.mem_we    = 1'b1;
  endtask

  task automatic idle();
    @(negedge clock);
    bus_if.mem_we   = 1'b0;
    bus_if.mem_addr = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic exp_hit;
    exp_hit = (a[31:4] == BASE[31:4]);
    @(negedge clock);
    bus_if.mem_we   = 1'b0;
    bus_if.mem_addr = a;
    #1;
    check(tag, bus_if.mem_rdata, exp);
    check({tag, "_hit"}, {31'd0, bus_if.hit}, {31'd0, exp_hit});
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'd0, tx_busy}, 32'd0);
  endtask

  // Line monitor: samples the middle of each of the 10 bit cells of a frame
  initial begin : line_monitor
    sb_t        e;
    logic [9:0] bits;
    logic [9:0] exp_fr;
    int         pos;
    int         tgt;
    forever begin
      @(negedge clock);
      if (mon_en && txd === 1'b0) begin
        checks++;
        assert (sb_q.size() > 0) else begin
          failures++;
          $error("FAIL mon_unexpected_frame observed=frame expected=none");
        end
        if (sb_q.size() > 0) begin
          e      = sb_q.pop_front();
          exp_fr = {1'b1, e.data, 1'b0};
          pos    = 0;
          for (int k = 0; k < 10; k++) begin
            tgt = k * e.bl + e.bl / 2;
            repeat (tgt - pos) @(negedge clock);
            pos     = tgt;
            bits[k] = txd;
          end
          repeat (10 * e.bl - 1 - pos) @(negedge clock);
          check("mon_frame", {22'd0, bits}, {22'd0, exp_fr});
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [9:0] fr;
    reset            = 1'b1;
    bus_if.mem_addr  = 32'd0;
    bus_if.mem_wdata = 32'd0;
    bus_if.mem_we    = 1'b0;
    repeat (3) @(negedge clock);

    // 1: reset state
    check("t1_txd_reset", {31'd0, txd}, 32'd1);
    check("t1_busy_reset", {31'd0, tx_busy}, 32'd0);
    reset = 1'b0;
    rd(BASE + 32'd4,  32'h0000_0004, "t1_status");
    rd(BASE + 32'd8,  32'd3,         "t1_div");
    rd(BASE + 32'd0,  32'd0,         "t1_txdata_rd");
    rd(BASE + 32'd12, 32'd0,         "t1_reserved");
    mon_en = 1'b1;

    // 2: single frame 8'hA5 at DIV = 3, checked every clock
    push_sb(8'hA5, 4);
    wr(BASE, 32'h0000_00A5);
    idle();
    check("t2_txd_before_pop", {31'd0, txd}, 32'd1);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      check("t2_txd_cycle", {31'd0, txd}, {31'd0, fr[k / 4]});
    end
    @(negedge clock);
    check("t2_busy_end", {31'd0, tx_busy}, 32'd0);
    rd(BASE + 32'd4, 32'h0000_0004, "t2_status_end");

    // 3: five back-to-back stores at DIV = 0, contiguous frames
    wr(BASE + 32'd8, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      push_sb(8'(i), 1);
      wr(BASE, 32'(i));
    end
    rd(BASE + 32'd4, 32'h0000_0043, "t3_status_full");
    repeat (46) @(negedge clock);
    check("t3_busy_e50", {31'd0, tx_busy}, 32'd1);
    @(negedge clock);
    check("t3_busy_e51", {31'd0, tx_busy}, 32'd0);

    // 4: overflow at DIV = 100, then clear OVF
    wr(BASE + 32'd8, 32'd100);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_sb(8'(8'h10 + i), 101);
      wr(BASE, 32'(8'h10 + i));
    end
    rd(BASE + 32'd4, 32'h0000_004B, "t4_status_ovf");
    wr(BASE + 32'd4, 32'h0000_0008);
    rd(BASE + 32'd4, 32'h0000_0043, "t4_status_ovf_clr");
    wait_idle(6000, "t4_drain");
    rd(BASE + 32'd4, 32'h0000_0004, "t4_status_end");

    // 5: DIV change mid-frame only affects the following frame
    wr(BASE + 32'd8, 32'd3);
    push_sb(8'h0F, 4);
    push_sb(8'h33, 2);
    wr(BASE, 32'h0000_000F);
    wr(BASE, 32'h0000_0033);
    idle();
    repeat (10) @(negedge clock);
    wr(BASE + 32'd8, 32'd1);
    rd(BASE + 32'd8, 32'd1, "t5_div");
    wait_idle(200, "t5_done");

    // 6: reset during data bit 3, then an out-of-window access
    mon_en = 1'b0;
    wr(BASE + 32'd8, 32'd3);
    wr(BASE, 32'h0000_0000);
    idle();
    repeat (18) @(negedge clock);
    check("t6_bit3_low", {31'd0, txd}, 32'd0);
    check("t6_busy_mid", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_txd_after_reset", {31'd0, txd}, 32'd1);
    check("t6_busy_after_reset", {31'd0, tx_busy}, 32'd0);
    reset = 1'b0;
    rd(BASE + 32'd4, 32'h0000_0004, "t6_status");
    rd(BASE + 32'd8, 32'd3, "t6_div_reset");
    wr(BASE + 32'd16, 32'h0000_0055);
    idle();
    rd(BASE + 32'd4, 32'h0000_0004, "t6_status_after_miss_wr");
    rd(BASE + 32'd16, 32'd0, "t6_miss_read");
    repeat (45) @(negedge clock);
    check("t6_txd_quiet", {31'd0, txd}, 32'd1);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
